apb_gpio_master_arb: RTL and testbench
======================================

Name: apb_gpio_master_arb

Overview:
Round-robin arbiter and APB master sequencer that shares one APB slave port (e.g. the GPIO register block) between NUM_REQ on-chip requesters such as the CPU bridge, the DMA engine and the debug port. It accepts one latched request at a time and runs a compliant IDLE/SETUP/ACCESS APB transfer. It supports slave wait states, captures read data and error, and returns a one-cycle response pulse to the winning requester. A timeout counter aborts transfers whose slave never asserts pready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_WIDTH, 32, APB data width
ADDR_WIDTH, 8, APB address width
TIMEOUT, 16, max ACCESS cycles without pready before abort; 0 = timeout disabled

Ports:
pclk  in  1  clock
preset  in  1  reset, synchronous, active-high
req_valid  in  NUM_REQ  per-requester request pending
req_write  in  NUM_REQ  per-requester 1 = write, 0 = read
req_addr  in  NUM_REQ*ADDR_WIDTH  flattened addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data
req_ready  out  NUM_REQ  one-hot accept pulse; request latched on this edge
rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid
rsp_err  out  1  pslverr or timeout, valid with rsp_valid
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
paddr  out  ADDR_WIDTH  APB address
pwdata  out  DATA_WIDTH  APB write data
prdata  in  DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB error
busy  out  1  state != IDLE

Behaviour:
- Reset: state IDLE. Outputs psel, penable, pwrite, req_ready, rsp_valid, rsp_err and busy = 0. paddr, pwdata and rsp_rdata = 0. Round-robin pointer last = NUM_REQ-1, so requester 0 wins first. Wait counter = 0.
- Reset is synchronous. Asserting it mid-transfer forces IDLE at the next edge. psel and penable drop at that edge. No rsp_valid is issued for the aborted transfer.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - If any req_valid is set, pick the winner g as the first set bit searching last+1, last+2 ... (mod NUM_REQ).
  - req_ready[g] = 1 combinationally in this cycle.
  - At the edge: latch pwrite, paddr and pwdata from requester g; set last = g; store g; go to SETUP.
  - With no request, stay in IDLE. paddr, pwdata and pwrite hold their last values.
- SETUP: psel = 1, penable = 0, unconditional move to ACCESS. Clear the wait counter.
- ACCESS: psel = 1, penable = 1.
  - If pready = 1: capture rsp_rdata (prdata on reads, 0 on writes) and rsp_err = pslverr. Assert rsp_valid[g] for exactly the next cycle. Go to IDLE.
  - Else, if TIMEOUT != 0 and the counter reaches TIMEOUT-1: rsp_rdata = 0, rsp_err = 1, pulse rsp_valid[g] next cycle, go to IDLE.
  - Else increment the counter.
- psel and penable decode from registered state only (glitch-free). pwrite, paddr and pwdata stay stable from SETUP through the last ACCESS cycle.
- Latency: grant at cycle T, SETUP at T+1, first ACCESS at T+2. With a zero-wait slave, rsp_valid is at T+3. Each slave wait cycle adds 1.
- Each transfer has at least one IDLE cycle between transfers. A new grant may occur in the same cycle as rsp_valid for the previous one.
- Requesters hold req_valid and their fields stable until req_ready. Dropping req_valid before it is granted is legal; the request is simply not served.
- rsp_rdata and rsp_err hold their value until the next completion.
- Counter width is $clog2(TIMEOUT+1); it never wraps.

Test Plan:
1. req0 writes addr 0x04, data 0x0000_FFFF, zero-wait slave, grant at T → psel at T+1; penable at T+2 with paddr = 0x04 and pwrite = 1; rsp_valid = 4'b0001 at T+3; rsp_err = 0; busy low at T+3.
2. req2 reads addr 0x0C, slave holds pready low for 3 ACCESS cycles then returns prdata = 0x0000_A5A5 → paddr stable throughout; rsp_valid[2] one cycle; rsp_rdata = 0x0000_A5A5.
3. All four req_valid held high with back-to-back requests → req_ready order 0, 1, 2, 3, 0. No cycle has more than one req_ready bit set. One IDLE cycle separates psel deassertion from the next SETUP.
4. req1 write, slave returns pslverr = 1 with pready → rsp_valid[1] with rsp_err = 1. The next transfer, error-free, gives rsp_err = 0.
5. TIMEOUT = 16, pready never asserted → exactly 16 ACCESS cycles, then psel = 0; rsp_valid pulse with rsp_err = 1 and rsp_rdata = 0; the next queued request is granted.
6. preset asserted during ACCESS of req3 → psel and penable = 0 after the edge; no rsp_valid[3]. After release, with all requesting, req0 is granted first.

Source files
------------

// File: rtl/apb_gpio_master_arb.sv
// Round-robin arbiter feeding a single APB master sequencer (IDLE/SETUP/ACCESS).
// One request is latched per transfer; completion is a one-cycle pulse to the winner.
module apb_gpio_master_arb #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                            pclk,
    input  logic                            preset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]           rsp_rdata,
    output logic                            rsp_err,
    output logic                            psel,
    output logic                            penable,
    output logic                            pwrite,
    output logic [ADDR_WIDTH-1:0]           paddr,
    output logic [DATA_WIDTH-1:0]           pwdata,
    input  logic [DATA_WIDTH-1:0]           prdata,
    input  logic                            pready,
    input  logic                            pslverr,
    output logic                            busy
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gnt;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   cand;
    logic               found;
    logic               any_req;
    logic               timeout_hit;
    logic [CNT_W-1:0]   wait_cnt;

    assign any_req = |req_valid;

    // Search starts one past the previous winner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = last;
        cand   = last;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        req_ready   = '0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    req_ready[winner] = 1'b1;
                    state_nxt         = ST_SETUP;
                end
            end
            ST_SETUP: state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    state_nxt = ST_IDLE;
                end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                    timeout_hit = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // APB strobes come straight from the state register so they cannot glitch.
    assign psel    = (state == ST_SETUP) || (state == ST_ACCESS);
    assign penable = (state == ST_ACCESS);
    assign busy    = (state != ST_IDLE);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= ST_IDLE;
            last      <= IDX_W'(NUM_REQ - 1);
            gnt       <= '0;
            pwrite    <= 1'b0;
            paddr     <= '0;
            pwdata    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        last   <= winner;
                        gnt    <= winner;
                        pwrite <= req_write[winner];
                        paddr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
                        pwdata <= req_wdata[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                ST_SETUP: wait_cnt <= '0;
                ST_ACCESS: begin
                    if (pready) begin
                        rsp_valid[gnt] <= 1'b1;
                        rsp_rdata      <= pwrite ? '0 : prdata;
                        rsp_err        <= pslverr;
                    end else if (timeout_hit) begin
                        rsp_valid[gnt] <= 1'b1;
                        rsp_rdata      <= '0;
                        rsp_err        <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_gpio_master_arb.sv
// Directed bench for apb_gpio_master_arb: latency, wait states, round-robin order,
// slave error, timeout abort and mid-transfer reset.
module tb_apb_gpio_master_arb;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int AW = 8;

    logic            pclk = 1'b0;
    logic            preset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_write;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [NR-1:0]   req_ready;
    logic [NR-1:0]   rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            psel;
    logic            penable;
    logic            pwrite;
    logic [AW-1:0]   paddr;
    logic [DW-1:0]   pwdata;
    logic [DW-1:0]   prdata;
    logic            pready;
    logic            pslverr;
    logic            busy;

    int total = 0;
    int bad   = 0;

    apb_gpio_master_arb #(
        .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(16)
    ) dut (
        .pclk(pclk), .preset(preset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .busy(busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge pclk);
        #2;
    endtask

    task automatic settle;
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clr_req(input int i);
        req_valid[i] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        preset    = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        tick;
        tick;
        settle;
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        preset = 1'b0;

        // 1: zero-wait write from req0
        set_req(0, 1'b1, 8'h04, 32'h0000_FFFF);
        settle;
        chk("t1_grant", req_ready, 4'b0001);
        chk("t1_idle_psel", psel, 0);
        tick;
        clr_req(0);
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_pen", penable, 0);
        chk("t1_setup_busy", busy, 1);
        tick;
        chk("t1_acc_pen", penable, 1);
        chk("t1_acc_paddr", paddr, 8'h04);
        chk("t1_acc_pwrite", pwrite, 1);
        chk("t1_acc_pwdata", pwdata, 32'h0000_FFFF);
        tick;
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_busy", busy, 0);
        chk("t1_psel_off", psel, 0);

        // 2: read from req2 with three wait cycles
        pready = 1'b0;
        set_req(2, 1'b0, 8'h0C, 32'h0);
        settle;
        chk("t2_grant", req_ready, 4'b0100);
        tick;
        clr_req(2);
        chk("t2_setup_paddr", paddr, 8'h0C);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_wait_pen", penable, 1);
            chk("t2_wait_paddr", paddr, 8'h0C);
            chk("t2_wait_pwrite", pwrite, 0);
            chk("t2_wait_rsp", rsp_valid, 0);
        end
        tick;
        pready = 1'b1;
        prdata = 32'h0000_A5A5;
        chk("t2_last_paddr", paddr, 8'h0C);
        tick;
        prdata = 32'h0;
        chk("t2_rsp_valid", rsp_valid, 4'b0100);
        chk("t2_rdata", rsp_rdata, 32'h0000_A5A5);
        chk("t2_err", rsp_err, 0);
        tick;
        chk("t2_rsp_pulse", rsp_valid, 0);
        chk("t2_rdata_hold", rsp_rdata, 32'h0000_A5A5);

        // 3: round robin with all requesters pending (fresh reset so req0 is first)
        preset = 1'b1;
        tick;
        preset = 1'b0;
        for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'(8'h10 + i), 32'(32'h100 + i));
        settle;
        for (int n = 0; n < 5; n++) begin
            chk("t3_grant", req_ready, 64'(1 << (n % 4)));
            chk("t3_idle_psel", psel, 0);
            if (n > 0) chk("t3_rsp", rsp_valid, 64'(1 << ((n - 1) % 4)));
            tick;
            chk("t3_setup_ready", req_ready, 0);
            chk("t3_setup_psel", psel, 1);
            chk("t3_setup_pen", penable, 0);
            tick;
            chk("t3_acc_pen", penable, 1);
            chk("t3_acc_paddr", paddr, 64'(8'h10 + (n % 4)));
            chk("t3_acc_pwdata", pwdata, 64'(32'h100 + (n % 4)));
            if (n == 4) req_valid = '0;
            tick;
            settle;
        end
        chk("t3_final_rsp", rsp_valid, 4'b0001);
        chk("t3_final_ready", req_ready, 0);

        // 4: slave error then clean transfer on req1
        pslverr = 1'b1;
        set_req(1, 1'b1, 8'h20, 32'h0000_1234);
        settle;
        chk("t4_grant", req_ready, 4'b0010);
        tick;
        clr_req(1);
        tick;
        tick;
        chk("t4_rsp_valid", rsp_valid, 4'b0010);
        chk("t4_err", rsp_err, 1);
        chk("t4_rdata_wr", rsp_rdata, 0);
        pslverr = 1'b0;
        prdata  = 32'h0000_5555;
        set_req(1, 1'b0, 8'h24, 32'h0);
        settle;
        chk("t4b_grant", req_ready, 4'b0010);
        tick;
        clr_req(1);
        tick;
        tick;
        chk("t4b_rsp_valid", rsp_valid, 4'b0010);
        chk("t4b_err", rsp_err, 0);
        chk("t4b_rdata", rsp_rdata, 32'h0000_5555);

        // 5: timeout with req0 queued behind req3
        pready = 1'b0;
        prdata = 32'hDEAD_DEAD;
        set_req(3, 1'b0, 8'h30, 32'h0);
        set_req(0, 1'b1, 8'h40, 32'h0000_BEEF);
        settle;
        chk("t5_grant", req_ready, 4'b1000);
        tick;
        clr_req(3);
        tick;
        acc = 0;
        for (int i = 0; i < 40 && penable; i++) begin
            acc++;
            tick;
        end
        chk("t5_access_cycles", acc, 16);
        chk("t5_psel_off", psel, 0);
        chk("t5_rsp_valid", rsp_valid, 4'b1000);
        chk("t5_err", rsp_err, 1);
        chk("t5_rdata", rsp_rdata, 0);
        chk("t5_next_grant", req_ready, 4'b0001);
        pready = 1'b1;
        tick;
        clr_req(0);
        tick;
        chk("t5b_paddr", paddr, 8'h40);
        chk("t5b_pwdata", pwdata, 32'h0000_BEEF);
        tick;
        chk("t5b_rsp_valid", rsp_valid, 4'b0001);
        chk("t5b_err", rsp_err, 0);

        // 6: reset during ACCESS of req3
        pready = 1'b0;
        set_req(3, 1'b0, 8'h33, 32'h0);
        settle;
        chk("t6_grant", req_ready, 4'b1000);
        tick;
        clr_req(3);
        tick;
        chk("t6_acc_pen", penable, 1);
        preset = 1'b1;
        tick;
        chk("t6_rst_psel", psel, 0);
        chk("t6_rst_pen", penable, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_rsp", rsp_valid, 0);
        preset = 1'b0;
        pready = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h50 + i), 32'h0);
        settle;
        chk("t6_first_grant", req_ready, 4'b0001);
        tick;
        req_valid = '0;
        chk("t6_setup_rsp", rsp_valid, 0);
        chk("t6_setup_paddr", paddr, 8'h50);
        tick;
        chk("t6_acc_rsp", rsp_valid, 0);
        tick;
        chk("t6_rsp_req0", rsp_valid, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
